// File: rtl/if_id_skid_if.sv
// Fetch-to-decode handshake bundle for the IF/ID skid buffer.
// master = the side driving fetch data and decode ready (bench or pipeline glue), slave = the buffer.
interface if_id_skid_if #(
  parameter int XLEN     = 64,
  parameter int INST_LEN = 32,
  parameter int TRAP_W   = 4
);
  logic                in_valid_i;
  logic                in_ready_o;
  logic [XLEN-1:0]     in_pc_i;
  logic [INST_LEN-1:0] in_inst_i;
  logic [TRAP_W-1:0]   in_trap_i;
  logic                out_valid_o;
  logic                out_ready_i;
  logic [XLEN-1:0]     out_pc_o;
  logic [INST_LEN-1:0] out_inst_o;
  logic [TRAP_W-1:0]   out_trap_o;

  modport master (
    output in_valid_i, in_pc_i, in_inst_i, in_trap_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_pc_o, out_inst_o, out_trap_o
  );

  modport slave (
    input  in_valid_i, in_pc_i, in_inst_i, in_trap_i, out_ready_i,
    output in_ready_o, out_valid_o, out_pc_o, out_inst_o, out_trap_o
  );
endinterface

// File: rtl/if_id_skid.sv
// IF/ID boundary: 2-entry FIFO skid buffer carrying {pc, inst, trap}.
// Both handshake outputs come from registered occupancy and flush only, so decode ready never reaches fetch.
module if_id_skid #(
  parameter int                  XLEN          = 64,
  parameter int                  INST_LEN      = 32,
  parameter int                  TRAP_W        = 4,
  parameter logic [XLEN-1:0]     PC_RESET_ADDR = 64'h8000_0000,
  parameter logic [INST_LEN-1:0] NOP_INST      = 32'h0000_0013
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  if_id_skid_if.slave  bus,
  output logic [1:0]   count_o
);

  logic [XLEN-1:0]     r_pc   [2];
  logic [INST_LEN-1:0] r_inst [2];
  logic [TRAP_W-1:0]   r_trap [2];
  logic                r_rdPtr;
  logic                r_wrPtr;
  logic [1:0]          r_count;

  logic w_inReady;
  logic w_outValid;
  logic w_push;
  logic w_pop;

  assign w_inReady  = (r_count != 2'd2) && !flush_i;
  assign w_outValid = (r_count != 2'd0) && !flush_i;
  assign w_push     = bus.in_valid_i && w_inReady;
  assign w_pop      = w_outValid && bus.out_ready_i;

  // Payload is masked to a NOP with no trap whenever decode must not consume it.
  assign bus.in_ready_o  = w_inReady;
  assign bus.out_valid_o = w_outValid;
  assign bus.out_pc_o    = r_pc[r_rdPtr];
  assign bus.out_inst_o  = w_outValid ? r_inst[r_rdPtr] : NOP_INST;
  assign bus.out_trap_o  = w_outValid ? r_trap[r_rdPtr] : '0;
  assign count_o         = r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= 2'd0;
      r_rdPtr <= 1'b0;
      r_wrPtr <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        r_pc[i]   <= PC_RESET_ADDR;
        r_inst[i] <= NOP_INST;
        r_trap[i] <= '0;
      end
    end else if (flush_i) begin
      r_count <= 2'd0;
      r_rdPtr <= 1'b0;
      r_wrPtr <= 1'b0;
    end else begin
      if (w_push) begin
        r_pc[r_wrPtr]   <= bus.in_pc_i;
        r_inst[r_wrPtr] <= bus.in_inst_i;
        r_trap[r_wrPtr] <= bus.in_trap_i;
        r_wrPtr         <= ~r_wrPtr;
      end
      if (w_pop) begin
        r_rdPtr <= ~r_rdPtr;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

endmodule

// File: tb/tb_if_id_skid.sv
// Self-checking bench for if_id_skid: a queue model checked every cycle, directed scenarios, then random traffic.
module tb_if_id_skid;
  localparam int          XLEN     = 64;
  localparam int          INST_LEN = 32;
  localparam int          TRAP_W   = 4;
  localparam logic [63:0] PC_RST   = 64'h8000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic [3:0]  trap;
  } entry_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [1:0] count;

  if_id_skid_if #(.XLEN(XLEN), .INST_LEN(INST_LEN), .TRAP_W(TRAP_W)) bus ();

  if_id_skid #(.XLEN(XLEN), .INST_LEN(INST_LEN), .TRAP_W(TRAP_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush),
    .bus     (bus),
    .count_o (count)
  );

  always #5 clk = ~clk;

  entry_t model[$];
  entry_t newEntry;
  logic   modelPush;
  logic   modelPop;
  int     checks   = 0;
  int     failures = 0;
  bit     checkEn  = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [63:0] pc, input logic [31:0] inst,
                               input logic [3:0] trap, input logic rdy, input logic fl);
    bus.in_valid_i  = v;
    bus.in_pc_i     = pc;
    bus.in_inst_i   = inst;
    bus.in_trap_i   = trap;
    bus.out_ready_i = rdy;
    flush           = fl;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Queue model: FIFO of at most two entries, emptied by reset or flush.
  always @(posedge clk) begin
    if (rst || flush) begin
      model.delete();
    end else begin
      modelPush = bus.in_valid_i && (model.size() < 2);
      modelPop  = (model.size() != 0) && bus.out_ready_i;
      if (modelPop) void'(model.pop_front());
      if (modelPush) begin
        newEntry.pc   = bus.in_pc_i;
        newEntry.inst = bus.in_inst_i;
        newEntry.trap = bus.in_trap_i;
        model.push_back(newEntry);
      end
    end
  end

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("count", {62'd0, count}, 64'(model.size()));
      checkOutput("in_ready", {63'd0, bus.in_ready_o}, {63'd0, (model.size() < 2) && !flush});
      checkOutput("out_valid", {63'd0, bus.out_valid_o}, {63'd0, (model.size() != 0) && !flush});
      if ((model.size() != 0) && !flush) begin
        checkOutput("out_pc", bus.out_pc_o, model[0].pc);
        checkOutput("out_inst", {32'd0, bus.out_inst_o}, {32'd0, model[0].inst});
        checkOutput("out_trap", {60'd0, bus.out_trap_o}, {60'd0, model[0].trap});
      end else begin
        checkOutput("idle_inst", {32'd0, bus.out_inst_o}, {32'd0, NOP});
        checkOutput("idle_trap", {60'd0, bus.out_trap_o}, 64'd0);
      end
    end
  end

  initial begin
    logic [31:0] prevInst;
    logic [31:0] curInst;

    rst = 1'b1;
    applyStimulus(1'b1, PC_RST, 32'h1234_5678, 4'h0, 1'b0, 1'b0);
    nextCycle();
    checkEn = 1'b1;
    nextCycle();
    rst = 1'b0;
    applyStimulus(1'b0, 64'd0, 32'd0, 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("rst_valid", {63'd0, bus.out_valid_o}, 64'd0);
    checkOutput("rst_ready", {63'd0, bus.in_ready_o}, 64'd1);
    checkOutput("rst_count", {62'd0, count}, 64'd0);
    checkOutput("rst_pc", bus.out_pc_o, 64'h8000_0000);
    checkOutput("rst_inst", {32'd0, bus.out_inst_o}, 64'h0000_0013);
    checkOutput("rst_trap", {60'd0, bus.out_trap_o}, 64'd0);
    nextCycle();

    $display("[TB] streaming");
    for (int k = 0; k < 4; k++) begin
      applyStimulus(k < 3, 64'h8000_0000 + 64'(4 * k), 32'h0000_0093 + 32'(k << 7), 4'h0, 1'b1, 1'b0);
      @(negedge clk);
      if (k > 0) begin
        checkOutput("stream_pc", bus.out_pc_o, 64'h8000_0000 + 64'(4 * (k - 1)));
        checkOutput("stream_count", {62'd0, count}, 64'd1);
      end
      nextCycle();
    end

    $display("[TB] backpressure");
    applyStimulus(1'b1, 64'h100, 32'h0010_0093, 4'h0, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 64'h104, 32'h0020_0113, 4'h0, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 64'h108, 32'h0030_0193, 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("full_count", {62'd0, count}, 64'd2);
    checkOutput("full_ready", {63'd0, bus.in_ready_o}, 64'd0);
    nextCycle();
    bus.out_ready_i = 1'b1;
    @(negedge clk);
    checkOutput("bp_headA", {32'd0, bus.out_inst_o}, 64'h0010_0093);
    checkOutput("bp_readyLow", {63'd0, bus.in_ready_o}, 64'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("bp_headB", {32'd0, bus.out_inst_o}, 64'h0020_0113);
    checkOutput("bp_readyHigh", {63'd0, bus.in_ready_o}, 64'd1);
    nextCycle();
    bus.in_valid_i = 1'b0;
    @(negedge clk);
    checkOutput("bp_headC", {32'd0, bus.out_inst_o}, 64'h0030_0193);
    nextCycle();

    $display("[TB] simultaneous push/pop");
    prevInst = 32'h00A0_0513;
    applyStimulus(1'b1, 64'h200, prevInst, 4'h0, 1'b0, 1'b0);
    nextCycle();
    for (int k = 0; k < 5; k++) begin
      curInst = 32'h0000_1013 + 32'(k << 7);
      applyStimulus(1'b1, 64'h204 + 64'(4 * k), curInst, 4'h0, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput("sim_head", {32'd0, bus.out_inst_o}, {32'd0, prevInst});
      checkOutput("sim_count", {62'd0, count}, 64'd1);
      prevInst = curInst;
      nextCycle();
    end
    applyStimulus(1'b0, 64'd0, 32'd0, 4'h0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("sim_last", {32'd0, bus.out_inst_o}, 64'h0000_1213);
    nextCycle();

    $display("[TB] flush while full");
    applyStimulus(1'b1, 64'h300, 32'h0050_0293, 4'h0, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 64'h304, 32'h0060_0313, 4'h0, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 64'h308, 32'hDEAD_BEEF, 4'h0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("fl_valid", {63'd0, bus.out_valid_o}, 64'd0);
    checkOutput("fl_ready", {63'd0, bus.in_ready_o}, 64'd0);
    checkOutput("fl_inst", {32'd0, bus.out_inst_o}, 64'h0000_0013);
    checkOutput("fl_count", {62'd0, count}, 64'd2);
    nextCycle();
    applyStimulus(1'b1, 64'h8000_1000, 32'h0070_0393, 4'h0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("postfl_count", {62'd0, count}, 64'd0);
    checkOutput("postfl_ready", {63'd0, bus.in_ready_o}, 64'd1);
    nextCycle();
    applyStimulus(1'b0, 64'd0, 32'd0, 4'h0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("postfl_valid", {63'd0, bus.out_valid_o}, 64'd1);
    checkOutput("postfl_pc", bus.out_pc_o, 64'h8000_1000);
    nextCycle();

    $display("[TB] trap passthrough");
    applyStimulus(1'b1, 64'h400, 32'h0080_0413, 4'b0010, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("trap_idle", {60'd0, bus.out_trap_o}, 64'd0);
    nextCycle();
    applyStimulus(1'b0, 64'd0, 32'd0, 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("trap_head", {60'd0, bus.out_trap_o}, 64'b0010);
    nextCycle();
    bus.out_ready_i = 1'b1;
    nextCycle();
    @(negedge clk);
    checkOutput("trap_gone", {60'd0, bus.out_trap_o}, 64'd0);
    nextCycle();

    $display("[TB] random traffic");
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(99, 0) == 0);
      applyStimulus($urandom_range(9, 0) < 7, {$urandom, $urandom}, $urandom,
                    4'($urandom_range(15, 0)), $urandom_range(9, 0) < 6,
                    $urandom_range(24, 0) == 0);
      nextCycle();
    end
    rst = 1'b0;
    applyStimulus(1'b0, 64'd0, 32'd0, 4'h0, 1'b1, 1'b0);
    nextCycle();
    nextCycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
